// File: rtl/decoder_scan_pkg.sv
// decoder_pkg: shared types and defaults for the registered N-to-2^N
// decoder family.
//   mode_e  : value carried on the `mode` input (DIRECT / SCAN)
//   state_e : registered operating state inside decoder_scan
//   DEF_N, DEF_DWELL_W : default index and dwell-counter widths
package decoder_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  typedef enum logic {
    S_DIRECT = 1'b0,
    S_SCAN   = 1'b1
  } state_e;

  localparam int DEF_N       = 3;
  localparam int DEF_DWELL_W = 8;

endpackage

// File: rtl/decoder_n_to_2n.sv
// decoder_n_to_2n: purely combinational N-to-2^N one-hot decoder with enable.
// It can stand in for the fixed-width decoders.
//   ena : 0 forces out to all zeros
//   in  : binary index, N bits
//   out : one-hot (ena=1) or zero (ena=0), 2^N bits
module decoder_n_to_2n #(
  parameter int N = 3
) (
  input  logic              ena,
  input  logic [N-1:0]      in,
  output logic [(1<<N)-1:0] out
);

  localparam int M = 1 << N;

  assign out = ena ? (M'(1) << in) : '0;

endmodule

// File: rtl/decoder_scan.sv
// decoder_scan: registered N-to-2^N one-hot decoder with an auto-scan mode.
// In DIRECT mode `in` is decoded to a registered one-hot strobe. In SCAN mode
// the pointer steps through every output and holds each one for dwell+1
// enabled cycles.
//   clk   : rising-edge clock
//   rst   : synchronous reset, active low
//   ena   : global enable; low blanks out (scan position and count freeze)
//   mode  : 0 = DIRECT, 1 = SCAN; sampled every cycle
//   in    : DIRECT index / SCAN load value
//   load  : SCAN only; force pointer to `in` and restart the dwell
//   dwell : extra cycles each SCAN position is held
//   out   : registered one-hot or zero select, 2^N bits
//   sel   : registered binary pointer
//   wrap  : one-cycle pulse when the pointer steps from 2^N-1 to 0
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int DWELL_W = DEF_DWELL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               mode,
  input  logic [N-1:0]       in,
  input  logic               load,
  input  logic [DWELL_W-1:0] dwell,
  output logic [(1<<N)-1:0]  out,
  output logic [N-1:0]       sel,
  output logic               wrap
);

  localparam int M = 1 << N;

  state_e             state;
  logic [N-1:0]       ptr, ptr_nxt;
  logic [DWELL_W-1:0] cnt, cnt_nxt, cnt_cur;
  logic               wrap_nxt;
  logic [M-1:0]       out_nxt;

  // Next-state logic. The out register is decoded from the next pointer, so
  // every scan branch reduces to onehot(ptr_nxt) gated by ena.
  always_comb begin
    ptr_nxt  = ptr;
    cnt_nxt  = cnt;
    wrap_nxt = 1'b0;
    // cnt is already zero after DIRECT. Gating on state keeps SCAN entry
    // clean even if that ever stops holding.
    cnt_cur  = (state == S_SCAN) ? cnt : '0;
    if (mode == MODE_SCAN) begin
      if (load) begin
        ptr_nxt = in;
        cnt_nxt = '0;
      end else if (!ena) begin
        cnt_nxt = cnt_cur;                  // freeze position and remaining dwell
      end else if (cnt_cur >= dwell) begin  // live compare: a lowered dwell advances at once
        cnt_nxt  = '0;
        ptr_nxt  = ptr + N'(1);
        wrap_nxt = (ptr == {N{1'b1}});
      end else begin
        cnt_nxt = cnt_cur + DWELL_W'(1);
      end
    end else begin
      ptr_nxt = in;                         // ptr tracks in, so SCAN resumes from here
      cnt_nxt = '0;
    end
  end

  decoder_n_to_2n #(.N(N)) u_dec (
    .ena (ena),
    .in  (ptr_nxt),
    .out (out_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_DIRECT;
      ptr   <= '0;
      cnt   <= '0;
      out   <= '0;
      wrap  <= 1'b0;
    end else begin
      state <= state_e'(mode);
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      out   <= out_nxt;
      wrap  <= wrap_nxt;
    end
  end

  assign sel = ptr;

endmodule

// File: tb/tb_decoder_scan.sv
// tb_decoder_scan: scoreboard bench for decoder_scan (N=3, DWELL_W=8).
// The driver applies one input vector per cycle at the falling edge. A
// behavioural model predicts the registered outputs after the next rising
// edge and queues them. A separate monitor pops and compares after each
// rising edge.
module tb_decoder_scan;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int M  = 1 << N;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ena = 1'b0;
  logic          mode = 1'b0;
  logic [N-1:0]  in = '0;
  logic          load = 1'b0;
  logic [DW-1:0] dwell = '0;
  logic [M-1:0]  out;
  logic [N-1:0]  sel;
  logic          wrap;

  decoder_scan #(.N(N), .DWELL_W(DW)) dut (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .mode  (mode),
    .in    (in),
    .load  (load),
    .dwell (dwell),
    .out   (out),
    .sel   (sel),
    .wrap  (wrap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [M-1:0] o;
    logic [N-1:0] s;
    logic         w;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Model state: the scan position and how long it has been shown.
  int m_pos  = 0;
  int m_held = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Apply one cycle of inputs and predict the outputs after the next edge.
  task automatic step(input bit r, input bit e, input bit md, input int i,
                      input bit ld, input int dw);
    exp_t x;
    bit   shown;
    bit   w;
    @(negedge clk);
    rst = r; ena = e; mode = md; in = i[N-1:0]; load = ld; dwell = dw[DW-1:0];
    w     = 1'b0;
    shown = e;
    if (!r) begin
      m_pos = 0; m_held = 0; shown = 1'b0;
    end else if (!md || ld) begin
      m_pos = i % M; m_held = 0;
    end else if (e) begin
      if (m_held >= dw) begin
        m_held = 0;
        w      = (m_pos == M - 1);
        m_pos  = (m_pos + 1) % M;
      end else begin
        m_held++;
      end
    end
    x.o = shown ? M'(1 << m_pos) : '0;
    x.s = N'(m_pos);
    x.w = w;
    q.push_back(x);
  endtask

  // Monitor
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        check("out",  int'(out),  int'(x.o));
        check("sel",  int'(sel),  int'(x.s));
        check("wrap", int'(wrap), int'(x.w));
        check("onehot0", int'($onehot0(out)), 1);
      end
    end
  end

  // Driver
  initial begin
    bit r, e, md, ld;
    int i, dw;
    // reset with mode=1, ena=1, then release into DIRECT with in=0
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    // DIRECT sweep and blanking
    for (int k = 0; k < M; k++) step(1, 1, 0, k, 0, 0);
    step(1, 0, 0, 5, 0, 0);
    // SCAN dwell=2 entered from in=6: 40 x3, 80 x3, then 01 with wrap
    step(1, 1, 0, 6, 0, 2);
    for (int k = 0; k < 9; k++) step(1, 1, 1, 6, 0, 2);
    // SCAN dwell=0: rotate every cycle
    for (int k = 0; k < 17; k++) step(1, 1, 1, 0, 0, 0);
    // load while disabled, then enable and cut dwell from 10 to 1 at cnt=5
    step(1, 0, 1, 3, 1, 10);
    for (int k = 0; k < 5; k++) step(1, 1, 1, 0, 0, 10);
    for (int k = 0; k < 3; k++) step(1, 1, 1, 0, 0, 1);
    // reset mid-scan while out=0x20 with a non-zero count
    step(1, 1, 1, 5, 1, 3);
    step(1, 1, 1, 0, 0, 3);
    step(1, 1, 1, 0, 0, 3);
    step(0, 1, 1, 0, 0, 3);
    step(1, 1, 1, 0, 0, 3);
    step(1, 1, 0, 2, 0, 3);
    // randomized phase with sticky mode and dwell
    md = 1'b1;
    dw = 1;
    for (int k = 0; k < 800; k++) begin
      r  = ($urandom_range(0, 59) != 0);
      e  = ($urandom_range(0, 7) != 0);
      ld = ($urandom_range(0, 15) == 0);
      i  = $urandom_range(0, M - 1);
      if ($urandom_range(0, 19) == 0) md = ~md;
      if ($urandom_range(0, 24) == 0)
        dw = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 3);
      step(r, e, md, i, ld, dw);
    end
    @(posedge clk);
    #3;
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
